// File: rtl/exu_imm_pkg.sv
// -----------------------------------------------------------------------------
// exu_imm_pkg
// Shared types and helpers for the multi-cycle I-type immediate execution unit.
//   op_e     : opcode encoding seen on the exu_imm_mc `op` port (9..15 illegal)
//   state_e  : sequencing FSM states
//   shamt_w  : width of the shift-amount field for a given XLEN
//   op_is_legal / op_is_shift : opcode classification helpers
// -----------------------------------------------------------------------------
package exu_imm_pkg;

  typedef enum logic [3:0] {
    OP_ADDI  = 4'd0,
    OP_SLTI  = 4'd1,
    OP_SLTIU = 4'd2,
    OP_XORI  = 4'd3,
    OP_ORI   = 4'd4,
    OP_ANDI  = 4'd5,
    OP_SLLI  = 4'd6,
    OP_SRLI  = 4'd7,
    OP_SRAI  = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_OPND  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  // Number of immediate bits that form the shift amount.
  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd8);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
  endfunction

endpackage

// File: rtl/exu_imm_alu.sv
// -----------------------------------------------------------------------------
// exu_imm_alu
// Purely combinational datapath for the immediate execution unit.
//   op        in  4        : opcode (exu_imm_pkg encoding)
//   operand   in  XLEN     : rs1 value (non-shift) or current accumulator (shift)
//   imm_sx    in  XLEN     : immediate sign-extended to XLEN
//   step_amt  in  SHAMT_W  : bits to shift in this single step
//   result    out XLEN     : non-shift result (ADDI/SLTI/SLTIU/XORI/ORI/ANDI)
//   shift_out out XLEN     : operand shifted once by step_amt per the shift op
// -----------------------------------------------------------------------------
module exu_imm_alu
  import exu_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [3:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [XLEN-1:0]    imm_sx,
  input  logic [SHAMT_W-1:0] step_amt,
  output logic [XLEN-1:0]    result,
  output logic [XLEN-1:0]    shift_out
);

  logic slt_s;
  logic slt_u;

  // SLTIU still compares against the sign-extended immediate, only unsigned.
  assign slt_s = $signed(operand) < $signed(imm_sx);
  assign slt_u = operand < imm_sx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so that unlisted opcodes cannot infer a latch.
    result = '0;
    case (op_e'(op))
      OP_ADDI:  result = operand + imm_sx;
      OP_SLTI:  result = {{(XLEN-1){1'b0}}, slt_s};
      OP_SLTIU: result = {{(XLEN-1){1'b0}}, slt_u};
      OP_XORI:  result = operand ^ imm_sx;
      OP_ORI:   result = operand | imm_sx;
      OP_ANDI:  result = operand & imm_sx;
      default:  result = '0;
    endcase
  end

  always_comb begin
    shift_out = operand;
    case (op_e'(op))
      OP_SLLI: shift_out = operand << step_amt;
      OP_SRLI: shift_out = operand >> step_amt;
      OP_SRAI: shift_out = $unsigned($signed(operand) >>> step_amt);
      default: shift_out = operand;
    endcase
  end

endmodule

// File: rtl/exu_imm_mc.sv
// -----------------------------------------------------------------------------
// exu_imm_mc
// Multi-cycle execution unit for RISC-V I-type immediate ALU operations with a
// start/done handshake and a serial shifter of SHAMT_STEP bits per cycle.
//
// Parameters
//   XLEN       : datapath width (32 or 64)
//   REG_AW     : register address width
//   SHAMT_STEP : bits shifted per SHIFT cycle, power of two in 1..XLEN
//
// Ports
//   hclk, hrst            : clock, synchronous active-high reset
//   start                 : issue strobe, only accepted while idle
//   op, imm, rd, rs1      : instruction fields, latched on accept
//   busy                  : high while the FSM is not IDLE
//   done, illegal         : one-cycle completion pulse / illegal-op flag
//   reg_raddr_1, reg_ren_1: register file read request
//   reg_rdata_1           : read data, valid the cycle after reg_ren_1
//   reg_waddr, reg_wen,
//   reg_wdata             : register file write
//
// Sequence: IDLE -> READ -> OPND -> [SHIFT ...] -> WB -> IDLE.
// Illegal opcodes go straight IDLE -> WB without touching the register file.
// -----------------------------------------------------------------------------
module exu_imm_mc
  import exu_imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int SHAMT_STEP = 1
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [11:0]       imm,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [REG_AW-1:0] reg_raddr_1,
  output logic              reg_ren_1,
  input  logic [XLEN-1:0]   reg_rdata_1,
  output logic [REG_AW-1:0] reg_waddr,
  output logic              reg_wen,
  output logic [XLEN-1:0]   reg_wdata
);

  localparam int SHAMT_W = shamt_w(XLEN);
  // One extra bit so that SHAMT_STEP == XLEN is representable.
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHAMT_STEP);

  state_e              state;
  logic [3:0]          op_q;
  logic [11:0]         imm_q;
  logic [REG_AW-1:0]   rd_q;
  logic [XLEN-1:0]     acc;
  logic [SHAMT_W-1:0]  cnt;
  logic                wen_q;

  logic [XLEN-1:0]     imm_sx;
  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;
  logic                last_step;
  logic [SHAMT_W-1:0]  step_amt;
  logic [XLEN-1:0]     alu_operand;
  logic [XLEN-1:0]     alu_result;
  logic [XLEN-1:0]     shift_out;
  logic [XLEN-1:0]     acc_d;
  logic                to_wb;

  // ---------------------------------------------------------------------------
  // Operand preparation
  // ---------------------------------------------------------------------------
  assign imm_sx   = {{(XLEN-12){imm_q[11]}}, imm_q};
  assign shamt    = imm_q[SHAMT_W-1:0];
  assign is_shift = op_is_shift(op_q);

  // The final step shifts by whatever is left, so cnt lands exactly on zero.
  assign last_step = ({1'b0, cnt} <= STEP);
  assign step_amt  = last_step ? cnt : STEP[SHAMT_W-1:0];

  // Non-shift ops work on the freshly read rs1; shift steps work on acc.
  assign alu_operand = (state == ST_SHIFT) ? acc : reg_rdata_1;

  exu_imm_alu #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .op        (op_q),
    .operand   (alu_operand),
    .imm_sx    (imm_sx),
    .step_amt  (step_amt),
    .result    (alu_result),
    .shift_out (shift_out)
  );

  // ---------------------------------------------------------------------------
  // Next accumulator value and "move to write-back" decision for the two
  // datapath states. Everything else keeps acc unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = acc;
    to_wb = 1'b0;
    case (state)
      ST_OPND: begin
        if (is_shift) begin
          acc_d = reg_rdata_1;
          to_wb = (shamt == '0);
        end else begin
          acc_d = alu_result;
          to_wb = 1'b1;
        end
      end
      ST_SHIFT: begin
        acc_d = shift_out;
        to_wb = last_step;
      end
      default: begin
        acc_d = acc;
        to_wb = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. Each output is set on the edge that
  // enters the state in which it must be visible, so nothing depends
  // combinationally on start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before this edge.
    if (hrst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      reg_ren_1   <= 1'b0;
      reg_raddr_1 <= '0;
      wen_q       <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
    end else begin
      // Pulse-type outputs default low every cycle.
      done      <= 1'b0;
      illegal   <= 1'b0;
      reg_ren_1 <= 1'b0;
      wen_q     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            imm_q <= imm;
            rd_q  <= rd;
            busy  <= 1'b1;
            if (!op_is_legal(op)) begin
              state     <= ST_WB;
              done      <= 1'b1;
              illegal   <= 1'b1;
              reg_waddr <= rd;
            end else begin
              state       <= ST_READ;
              reg_ren_1   <= 1'b1;
              reg_raddr_1 <= rs1;
            end
          end
        end

        ST_READ: begin
          state <= ST_OPND;
        end

        ST_OPND: begin
          acc <= acc_d;
          cnt <= shamt;
          if (to_wb) begin
            state     <= ST_WB;
            done      <= 1'b1;
            wen_q     <= (rd_q != '0);
            reg_waddr <= rd_q;
            reg_wdata <= acc_d;
          end else begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          acc <= acc_d;
          cnt <= cnt - step_amt;
          if (to_wb) begin
            state     <= ST_WB;
            done      <= 1'b1;
            wen_q     <= (rd_q != '0);
            reg_waddr <= rd_q;
            reg_wdata <= acc_d;
          end
        end

        ST_WB: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A reset arriving during WB must also cancel the write the register file
  // would otherwise capture on that same edge.
  assign reg_wen = wen_q & ~hrst;

endmodule

// File: tb/tb_exu_imm_mc.sv
// -----------------------------------------------------------------------------
// tb_exu_imm_mc
// Drives two instances side by side with identical instruction fields:
//   dut_a : XLEN=32, SHAMT_STEP=1
//   dut_b : XLEN=64, SHAMT_STEP=8
// Each has its own register-file model. Results and latencies are compared
// against a plain-arithmetic reference model of the I-type rules.
// -----------------------------------------------------------------------------
module tb_exu_imm_mc;

  localparam int STEP_A = 1;
  localparam int STEP_B = 8;

  logic        hclk;
  logic        hrst;
  logic        start;
  logic [3:0]  op;
  logic [11:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;

  logic        a_busy, a_done, a_illegal, a_ren, a_wen;
  logic [4:0]  a_raddr, a_waddr;
  logic [31:0] a_rdata, a_wdata;

  logic        b_busy, b_done, b_illegal, b_ren, b_wen;
  logic [4:0]  b_raddr, b_waddr;
  logic [63:0] b_rdata, b_wdata;

  logic [31:0] regs_a [32];
  logic [63:0] regs_b [32];

  int total;
  int bad;

  logic [63:0] last_wdata_a;
  logic [63:0] last_wdata_b;

  exu_imm_mc #(.XLEN(32), .REG_AW(5), .SHAMT_STEP(STEP_A)) dut_a (
    .hclk(hclk), .hrst(hrst), .start(start), .op(op), .imm(imm), .rd(rd), .rs1(rs1),
    .busy(a_busy), .done(a_done), .illegal(a_illegal),
    .reg_raddr_1(a_raddr), .reg_ren_1(a_ren), .reg_rdata_1(a_rdata),
    .reg_waddr(a_waddr), .reg_wen(a_wen), .reg_wdata(a_wdata)
  );

  exu_imm_mc #(.XLEN(64), .REG_AW(5), .SHAMT_STEP(STEP_B)) dut_b (
    .hclk(hclk), .hrst(hrst), .start(start), .op(op), .imm(imm), .rd(rd), .rs1(rs1),
    .busy(b_busy), .done(b_done), .illegal(b_illegal),
    .reg_raddr_1(b_raddr), .reg_ren_1(b_ren), .reg_rdata_1(b_rdata),
    .reg_waddr(b_waddr), .reg_wen(b_wen), .reg_wdata(b_wdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Register file read ports: data appears the cycle after the request.
  always @(posedge hclk) begin
    if (a_ren) a_rdata <= regs_a[a_raddr];
    if (b_ren) b_rdata <= regs_b[b_raddr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: I-type semantics at a given width, plain arithmetic.
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_result(input int xlen, input logic [3:0] o,
                                             input logic [63:0] a_in, input logic [11:0] im);
    logic [63:0]        mask;
    logic [63:0]        a;
    longint             sa;
    logic signed [11:0] si;
    longint             simm;
    logic [63:0]        uimm;
    int                 sh;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a    = a_in & mask;
    sa   = (xlen == 64) ? longint'(a) : longint'(int'(a[31:0]));
    si   = im;
    simm = si;
    uimm = 64'(simm) & mask;
    sh   = int'(im) % xlen;
    case (o)
      4'd0:    return (a + uimm) & mask;
      4'd1:    return (sa < simm) ? 64'd1 : 64'd0;
      4'd2:    return (a < uimm) ? 64'd1 : 64'd0;
      4'd3:    return a ^ uimm;
      4'd4:    return a | uimm;
      4'd5:    return a & uimm;
      4'd6:    return (a << sh) & mask;
      4'd7:    return a >> sh;
      4'd8:    return 64'(sa >>> sh) & mask;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_latency(input int xlen, input int step, input logic [3:0] o,
                                     input logic [11:0] im);
    int sh;
    sh = int'(im) % xlen;
    if (o > 4'd8) return 1;
    if (o >= 4'd6) return 3 + (sh + step - 1) / step;
    return 3;
  endfunction

  // ---------------------------------------------------------------------------
  // Issue one instruction to both units and check everything observable.
  // pulse_at > 0 raises a second start for one cycle while the units are busy.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [3:0] o, input logic [11:0] im,
                        input logic [4:0] d, input logic [4:0] s,
                        input logic [63:0] va, input logic [63:0] vb, input int pulse_at);
    int          lat_a, lat_b, exp_lat_a, exp_lat_b;
    int          n_done_a, n_done_b, n_ren_a, n_ren_b, stray_w;
    logic        wen_a, wen_b, ill_a, ill_b, legal, exp_wen;
    logic [4:0]  wa_a, wa_b;
    logic [63:0] exp_a, exp_b;
    bit          fin;
    lat_a = -1; lat_b = -1;
    n_done_a = 0; n_done_b = 0; n_ren_a = 0; n_ren_b = 0; stray_w = 0;
    wen_a = 0; wen_b = 0; ill_a = 0; ill_b = 0; wa_a = '0; wa_b = '0;
    last_wdata_a = '0; last_wdata_b = '0;
    fin = 0;
    legal     = (o <= 4'd8);
    exp_wen   = legal && (d != 5'd0);
    exp_a     = ref_result(32, o, va, im);
    exp_b     = ref_result(64, o, vb, im);
    exp_lat_a = ref_latency(32, STEP_A, o, im);
    exp_lat_b = ref_latency(64, STEP_B, o, im);

    if (s != 5'd0) begin
      regs_a[s] = va[31:0];
      regs_b[s] = vb;
    end else begin
      regs_a[0] = 32'd0;
      regs_b[0] = 64'd0;
      exp_a = ref_result(32, o, 64'd0, im);
      exp_b = ref_result(64, o, 64'd0, im);
    end

    @(negedge hclk);
    start = 1'b1; op = o; imm = im; rd = d; rs1 = s;

    for (int cyc = 1; cyc <= 150 && !fin; cyc++) begin
      @(negedge hclk);
      if (a_done) begin
        n_done_a++; lat_a = cyc; wen_a = a_wen; wa_a = a_waddr;
        ill_a = a_illegal; last_wdata_a = 64'(a_wdata);
      end
      if (b_done) begin
        n_done_b++; lat_b = cyc; wen_b = b_wen; wa_b = b_waddr;
        ill_b = b_illegal; last_wdata_b = b_wdata;
      end
      if (a_ren) n_ren_a++;
      if (b_ren) n_ren_b++;
      if ((a_wen && !a_done) || (b_wen && !b_done)) stray_w++;
      if (cyc == 1) start = 1'b0;
      if (pulse_at > 0 && cyc == pulse_at) begin
        start = 1'b1; op = 4'd0; imm = 12'h123; rd = 5'd9; rs1 = 5'd3;
      end
      if (pulse_at > 0 && cyc == pulse_at + 1) start = 1'b0;
      if (lat_a > 0 && lat_b > 0 && cyc >= ((lat_a > lat_b) ? lat_a : lat_b) + 2) begin
        fin = 1;
        check({tag, "_busy_a_after"}, 64'(a_busy), 64'd0);
        check({tag, "_busy_b_after"}, 64'(b_busy), 64'd0);
      end
    end

    check({tag, "_lat_a"}, 64'(lat_a), 64'(exp_lat_a));
    check({tag, "_lat_b"}, 64'(lat_b), 64'(exp_lat_b));
    check({tag, "_ndone_a"}, 64'(n_done_a), 64'd1);
    check({tag, "_ndone_b"}, 64'(n_done_b), 64'd1);
    check({tag, "_ill_a"}, 64'(ill_a), 64'(!legal));
    check({tag, "_ill_b"}, 64'(ill_b), 64'(!legal));
    check({tag, "_wen_a"}, 64'(wen_a), 64'(exp_wen));
    check({tag, "_wen_b"}, 64'(wen_b), 64'(exp_wen));
    check({tag, "_nren_a"}, 64'(n_ren_a), 64'(legal));
    check({tag, "_nren_b"}, 64'(n_ren_b), 64'(legal));
    check({tag, "_stray_wen"}, 64'(stray_w), 64'd0);
    if (exp_wen) begin
      check({tag, "_waddr_a"}, 64'(wa_a), 64'(d));
      check({tag, "_waddr_b"}, 64'(wa_b), 64'(d));
      check({tag, "_wdata_a"}, last_wdata_a, exp_a);
      check({tag, "_wdata_b"}, last_wdata_b, exp_b);
    end
  endtask

  // Start a long shift, then reset in the middle of the SHIFT phase.
  task automatic reset_mid_shift();
    int n_evt;
    regs_a[4] = 32'h0000_0003;
    regs_b[4] = 64'h3;
    @(negedge hclk);
    start = 1'b1; op = 4'd6; imm = 12'd20; rd = 5'd8; rs1 = 5'd4;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge hclk);
      if (cyc == 1) start = 1'b0;
    end
    check("rst_mid_busy_a_before", 64'(a_busy), 64'd1);
    check("rst_mid_busy_b_before", 64'(b_busy), 64'd1);
    hrst = 1'b1;
    @(negedge hclk);
    hrst = 1'b0;
    check("rst_mid_busy_a", 64'(a_busy), 64'd0);
    check("rst_mid_busy_b", 64'(b_busy), 64'd0);
    n_evt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge hclk);
      if (a_wen || b_wen || a_done || b_done) n_evt++;
    end
    check("rst_mid_no_write", 64'(n_evt), 64'd0);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_va, r_vb;
    int          sel;
    total = 0; bad = 0;
    hrst = 1'b1; start = 1'b0; op = '0; imm = '0; rd = '0; rs1 = '0;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = 32'd0;
      regs_b[i] = 64'd0;
    end
    repeat (3) @(negedge hclk);
    hrst = 1'b0;

    check("rst_busy",    64'(a_busy),    64'd0);
    check("rst_done",    64'(a_done),    64'd0);
    check("rst_illegal", 64'(a_illegal), 64'd0);
    check("rst_ren",     64'(a_ren),     64'd0);
    check("rst_wen",     64'(a_wen),     64'd0);
    check("rst_raddr",   64'(a_raddr),   64'd0);
    check("rst_waddr",   64'(a_waddr),   64'd0);
    check("rst_wdata",   64'(a_wdata),   64'd0);
    check("rst_wen_b",   64'(b_wen),     64'd0);

    // Directed cases.
    run_op("addi", 4'd0, 12'hFFF, 5'd7, 5'd5, 64'h10, 64'h10, 0);
    check("addi_const", last_wdata_a, 64'h0000_000F);

    run_op("slti", 4'd1, 12'h001, 5'd6, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("slti_const", last_wdata_a, 64'd1);
    run_op("sltiu", 4'd2, 12'h001, 5'd6, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("sltiu_const", last_wdata_a, 64'd0);
    run_op("sltiu_m1", 4'd2, 12'hFFF, 5'd6, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("sltiu_m1_const", last_wdata_a, 64'd0);

    // Upper immediate bits (0x400 as in the real SRAI encoding) are ignored.
    run_op("srai31", 4'd8, 12'h41F, 5'd10, 5'd11, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 0);
    check("srai31_const", last_wdata_a, 64'hFFFF_FFFF);
    run_op("srli31", 4'd7, 12'h01F, 5'd10, 5'd11, 64'h8000_0000, 64'h8000_0000, 0);
    check("srli31_const", last_wdata_a, 64'h1);

    run_op("slli0", 4'd6, 12'h000, 5'd12, 5'd13, 64'h1234_5678, 64'hDEAD_BEEF_1234_5678, 0);
    check("slli0_const", last_wdata_a, 64'h1234_5678);
    run_op("slli40", 4'd6, 12'd40, 5'd12, 5'd13, 64'h1, 64'h1, 0);
    check("slli40_const_b", last_wdata_b, 64'h0000_0100_0000_0000);

    run_op("rd0", 4'd3, 12'h0F0, 5'd0, 5'd14, 64'hAAAA_5555, 64'hAAAA_5555, 0);
    run_op("illegal", 4'hF, 12'h123, 5'd15, 5'd16, 64'h1, 64'h1, 0);

    // A start while busy must be ignored: exactly one done per unit.
    run_op("ignore_start", 4'd8, 12'h01F, 5'd17, 5'd18, 64'h8000_0000, 64'hF000_0000_0000_0000, 3);

    // Randomized operations, including occasional illegal opcodes.
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 11);
      r_op = (sel < 9) ? 4'(sel) : 4'($urandom_range(9, 15));
      r_va = {32'd0, $urandom};
      r_vb = {$urandom, $urandom};
      run_op($sformatf("rnd%0d", n), r_op, 12'($urandom), 5'($urandom_range(0, 31)),
             5'($urandom_range(1, 31)), r_va, r_vb, 0);
    end

    reset_mid_shift();

    // Still operational after the mid-operation reset.
    run_op("after_rst", 4'd0, 12'h7FF, 5'd20, 5'd21, 64'hFFFF_FFFF, 64'h1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
